// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer code conversions, used by both the read-side and
// write-side controllers.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_W      = 5;
  localparam int unsigned FIFO_SYNC_STAGES = 2;

  // Width-generic: callers zero-extend into 32 bits and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO controller bus: read request and incoming write pointer in, memory
// address, read pointer and status flags out.
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = FIFO_ADDR_W
);

  logic              rd_en;
  logic [ADDR_W:0]   w_ptr_gray;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_ptr_gray;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_count;
  logic              underflow;

  // master: the read client / write-domain side; slave: the controller itself.
  modport master (
    output rd_en, w_ptr_gray,
    input  r_addr, r_ptr_gray, empty, almost_empty, rd_count, underflow
  );

  modport slave (
    input  rd_en, w_ptr_gray,
    output r_addr, r_ptr_gray, empty, almost_empty, rd_count, underflow
  );

endinterface

// File: rtl/ptr_sync.sv
// Multi-flop pointer synchroniser with asynchronous clear; used in both FIFO clock
// domains to bring the opposite gray pointer across.
module ptr_sync #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic             r_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-domain controller: synchronises the write pointer, advances the read
// pointer on accepted reads and keeps registered empty / almost_empty / count / underflow.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W      = FIFO_ADDR_W,
  parameter int unsigned SYNC_STAGES = FIFO_SYNC_STAGES,
  parameter int unsigned AE_THRESH   = 4
) (
  input logic           r_clk,
  input logic           rst_n,
  fifo_rd_ctrl_if.slave bus
);

  localparam int unsigned PtrW = ADDR_W + 1;

  logic [PtrW-1:0] wq;
  logic [PtrW-1:0] wq_bin;
  logic            rd_ok;
  logic [PtrW-1:0] r_bin_d, r_bin_q;
  logic [PtrW-1:0] r_gray_d, r_gray_q;
  logic [PtrW-1:0] count_d, count_q;
  logic            empty_d, empty_q;
  logic            ae_d, ae_q;
  logic            uf_d, uf_q;

  ptr_sync #(
    .WIDTH  (PtrW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .r_clk (r_clk),
    .rst_n (rst_n),
    .d     (bus.w_ptr_gray),
    .q     (wq)
  );

  always_comb begin
    wq_bin   = PtrW'(gray2bin(32'(wq)));
    rd_ok    = bus.rd_en & ~empty_q;
    r_bin_d  = r_bin_q + PtrW'(rd_ok);
    r_gray_d = PtrW'(bin2gray(32'(r_bin_d)));
    // Flags use the post-read pointer so the last-word read empties on the same edge.
    count_d  = wq_bin - r_bin_d;
    empty_d  = (r_gray_d == wq);
    ae_d     = (32'(count_d) <= AE_THRESH);
    uf_d     = bus.rd_en & empty_q;
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin_q  <= '0;
      r_gray_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
      uf_q     <= 1'b0;
    end else begin
      r_bin_q  <= r_bin_d;
      r_gray_q <= r_gray_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      ae_q     <= ae_d;
      uf_q     <= uf_d;
    end
  end

  assign bus.r_addr       = r_bin_q[ADDR_W-1:0];
  assign bus.r_ptr_gray   = r_gray_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.rd_count     = count_q;
  assign bus.underflow    = uf_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed and randomized reads/writes against a counting
// reference model, with a 2-stage and a 3-stage instance.
module tb_fifo_rd_ctrl;

  logic r_clk = 1'b0;
  logic rst2;
  logic rst3;

  always #5 r_clk = ~r_clk;

  fifo_rd_ctrl_if #(.ADDR_W(5)) bus2 ();
  fifo_rd_ctrl_if #(.ADDR_W(5)) bus3 ();

  fifo_rd_ctrl #(
    .ADDR_W      (5),
    .SYNC_STAGES (2),
    .AE_THRESH   (4)
  ) dut2 (
    .r_clk (r_clk),
    .rst_n (rst2),
    .bus   (bus2)
  );

  fifo_rd_ctrl #(
    .ADDR_W      (5),
    .SYNC_STAGES (3),
    .AE_THRESH   (4)
  ) dut3 (
    .r_clk (r_clk),
    .rst_n (rst3),
    .bus   (bus3)
  );

  int tests  = 0;
  int failed = 0;

  // Model: words written (wb) and read (reads) as plain counts; the synchroniser is a
  // history of write counts sampled at each edge.
  int sel = 2;
  int s_stages = 2;
  int wb = 0;
  int reads = 0;
  int hist[8];
  bit m_empty, m_ae, m_uf;
  int m_cnt;

  function automatic logic [5:0] g6(input int b);
    logic [5:0] x;
    x = 6'(b % 64);
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    reads = 0;
    for (int i = 0; i < 8; i++) hist[i] = 0;
    m_empty = 1'b1;
    m_ae    = 1'b1;
    m_uf    = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_edge(input bit ren);
    int seen;
    seen = hist[s_stages-1];
    m_uf = ren && m_empty;
    if (ren && !m_empty) reads++;
    m_cnt   = (seen - (reads % 64) + 64) % 64;
    m_empty = (m_cnt == 0);
    m_ae    = (m_cnt <= 4);
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = wb % 64;
  endtask

  function automatic logic [5:0] cur_gray();
    return (sel == 2) ? bus2.r_ptr_gray : bus3.r_ptr_gray;
  endfunction

  function automatic logic [4:0] cur_addr();
    return (sel == 2) ? bus2.r_addr : bus3.r_addr;
  endfunction

  function automatic logic cur_empty();
    return (sel == 2) ? bus2.empty : bus3.empty;
  endfunction

  task automatic check_all(input string ph);
    logic [5:0] cnt;
    logic       ae, uf;
    cnt = (sel == 2) ? bus2.rd_count     : bus3.rd_count;
    ae  = (sel == 2) ? bus2.almost_empty : bus3.almost_empty;
    uf  = (sel == 2) ? bus2.underflow    : bus3.underflow;
    check({ph, ".addr"},  32'(cur_addr()),  32'(reads % 32));
    check({ph, ".gray"},  32'(cur_gray()),  32'(g6(reads)));
    check({ph, ".empty"}, 32'(cur_empty()), 32'(m_empty));
    check({ph, ".ae"},    32'(ae),          32'(m_ae));
    check({ph, ".count"}, 32'(cnt),         32'(m_cnt));
    check({ph, ".uflow"}, 32'(uf),          32'(m_uf));
  endtask

  // Drive inputs, take one edge, update the model, then compare just after the edge.
  task automatic step(input bit ren, input string ph);
    bit in_reset;
    if (sel == 2) begin
      bus2.rd_en      = ren;
      bus2.w_ptr_gray = g6(wb);
    end else begin
      bus3.rd_en      = ren;
      bus3.w_ptr_gray = g6(wb);
    end
    @(posedge r_clk);
    in_reset = (sel == 2) ? !rst2 : !rst3;
    if (in_reset) model_reset();
    else          model_edge(ren);
    #1;
    check_all(ph);
  endtask

  initial begin
    int lat;
    int wraps;
    int cyc;
    bit saw_top, saw_wrap;
    logic [4:0] prev_addr;

    rst2 = 1'b0;
    rst3 = 1'b0;
    bus2.rd_en = 1'b0;
    bus2.w_ptr_gray = '0;
    bus3.rd_en = 1'b0;
    bus3.w_ptr_gray = '0;
    model_reset();
    #12;
    sel = 3;
    check_all("rst3");
    sel = 2;
    check_all("rst2");
    rst2 = 1'b1;
    rst3 = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b1, "uflow");

    // Empty deassert latency with two stages.
    wb  = 1;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, "lat2");
      if (lat == 0 && !cur_empty()) lat = i;
    end
    check("lat2.edges", 32'(lat), 32'd3);
    step(1'b1, "lastword");
    check("lastword.gray", 32'(cur_gray()), 32'b000001);

    // Fill level and almost_empty boundary.
    wb = reads + 10;
    for (int i = 0; i < 3; i++) step(1'b0, "fill");
    for (int i = 0; i < 6; i++) step(1'b1, "drain6");

    // Full FIFO drained word by word.
    wb = reads + 32;
    for (int i = 0; i < 3; i++) step(1'b0, "full");
    for (int i = 0; i < 32; i++) step(1'b1, "drain32");
    step(1'b1, "postdrain");

    // Randomized stream across pointer wrap, write side never more than 32 ahead.
    begin
      int target;
      target    = reads + 70;
      wraps     = 0;
      saw_top   = 1'b0;
      saw_wrap  = 1'b0;
      cyc       = 0;
      prev_addr = cur_addr();
      while (reads < target && cyc < 2000) begin
        if (wb - reads < 32 && $urandom_range(0, 3) != 0) wb++;
        step($urandom_range(0, 4) != 0, "stream");
        if (prev_addr == 5'd31 && cur_addr() == 5'd0) wraps++;
        if (cur_gray() == 6'b100000) saw_top = 1'b1;
        if (saw_top && cur_gray() == 6'b000000) saw_wrap = 1'b1;
        prev_addr = cur_addr();
        cyc++;
      end
      check("stream.done",  32'(reads >= target), 32'd1);
      check("stream.wraps", 32'(wraps),           32'd2);
      check("stream.top",   32'(saw_top),         32'd1);
      check("stream.zero",  32'(saw_wrap),        32'd1);
    end

    // Three-stage instance: asynchronous reset mid-cycle, then 4-edge deassert latency.
    bus2.rd_en = 1'b0;
    sel        = 3;
    s_stages   = 3;
    wb         = 5;
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b0, "pre3");
    check("pre3.count", 32'(bus3.rd_count), 32'd5);
    #2;
    rst3 = 1'b0;
    #1;
    model_reset();
    check_all("async3");
    step(1'b0, "hold3");
    #2;
    rst3 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, "lat3");
      if (lat == 0 && !cur_empty()) lat = i;
    end
    check("lat3.edges", 32'(lat), 32'd4);
    for (int i = 0; i < 6; i++) step(1'b1, "drain3");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
